quick_queue_top: RTL and testbench
==================================

// Module: quick_queue_top
// PURPOSE
//  FIFO of (left,right) 32-bit bound pairs: the pending-subarray work queue of the QuickQ
//  quicksort engine. The partition stage pushes subarray bounds and the sort core pops them.
//  array_size sets the run-time capacity, so one build serves many problem sizes.
// PARAMETERS
//  DATA_W  32   width of each bound (lt and rt)
//  DEPTH   256  physical entries; array_size is 8 bits, so the limit is 256
// PORTS
//  clk         in   1       rising-edge clock
//  rst         in   1       asynchronous, active-low reset (0 = reset)
//  enq         in   1       push {data_lt_i,data_rt_i} this cycle
//  deq         in   1       pop head this cycle
//  array_size  in   8       run-time capacity; 0 means DEPTH
//  data_lt_i   in   DATA_W  left bound to push
//  data_rt_i   in   DATA_W  right bound to push
//  data_lt_o   out  DATA_W  left bound of the last popped pair (registered)
//  data_rt_o   out  DATA_W  right bound of the last popped pair (registered)
// BEHAVIOUR
//  - Reset: rst=0 asynchronously clears count, rd_ptr, wr_ptr, data_lt_o and data_rt_o to 0.
//    Storage contents are don't-care. Reset may hit mid-operation; queue contents are lost.
//  - cap = (array_size==0) ? DEPTH : array_size. Values above DEPTH cannot occur.
//  - empty = (count==0). full = (count >= cap).
//  - Enqueue: enq && !full -> mem[wr_ptr] <= {lt,rt}; wr_ptr++; count++.
//    enq && full -> silently dropped.
//  - Dequeue: deq && !empty -> {data_lt_o,data_rt_o} <= mem[rd_ptr] at that edge, so the
//    value is visible 1 cycle after the deq edge; rd_ptr++; count--.
//    deq && empty -> no-op; outputs hold their value.
//  - Outputs change only on a successful pop or reset. Otherwise they hold (no show-ahead).
//  - Simultaneous enq && deq:
//    non-empty -> both occur, count unchanged (allowed even when full);
//    empty -> enqueue only, no bypass to the outputs.
//  - Pointers wrap modulo DEPTH (8-bit natural wrap when DEPTH=256).
//    Ordering is strict FIFO across the wrap.
//  - Lowering array_size below count keeps all entries. Pops still work; pushes are blocked
//    until count < cap.
//  - Inputs are sampled only on the clk rising edge. Input values are stored as-is, and
//    data_rt_i is stored even when the engine leaves it unused.
// STRUCTURE
//  - Package qq_pkg:
//      DATA_W and DEPTH constants
//      typedef struct packed {logic [DATA_W-1:0] lt, rt;} bound_pair_t
//      typedef logic [$clog2(DEPTH):0] qq_count_t
//  - Sub-module qq_pair_ram: DEPTH x bound_pair_t, 1 synchronous write port and
//    1 synchronous read port. Its registered read port drives data_*_o directly.
//  - The top holds the pointers, count, cap and full/empty logic, and the pop/push enables.
// TESTING
//  1 Reset, array_size=3, deq=1 for 5 cycles on the empty queue -> data_lt_o=data_rt_o=0
//    throughout; count stays 0.
//  2 enq 1 cycle with lt=4, rt=9, then idle 10 cycles -> outputs stay 0.
//    Then deq 1 cycle -> next cycle lt_o=4, rt_o=9, and the outputs hold afterward.
//  3 array_size=3; enq (1,10),(2,20),(3,30),(4,40); then deq x4 -> outputs 1/10, 2/20,
//    3/30, then hold 3/30; (4,40) was dropped.
//  4 Queue holds (5,50); enq (6,60) && deq in the same cycle -> outputs 5/50, count stays 1.
//    Next deq -> 6/60.
//  5 array_size=0; push 300 pairs with lt=i, popping once every 2 cycles -> pops are in
//    order across the pointer wrap; pushes made while count=256 are dropped.
//  6 Assert rst=0 mid-stream between clock edges -> outputs read 0 immediately.
//    After release, deq reads as empty.

Source files
------------

// File: rtl/qq_pkg.sv
// qq_pkg
// Shared constants and types for the QuickQ pending-subarray work queue.
//   DATA_W        width of one subarray bound
//   DEPTH         physical queue entries
//   PTR_W         pointer width (index into DEPTH entries)
//   bound_pair_t  one queue entry {lt, rt}
//   qq_count_t    occupancy count, wide enough to hold DEPTH itself
package qq_pkg;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 256;
    localparam int PTR_W  = $clog2(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] lt;
        logic [DATA_W-1:0] rt;
    } bound_pair_t;

    typedef logic [$clog2(DEPTH):0] qq_count_t;
    typedef logic [PTR_W-1:0]       qq_ptr_t;

endpackage

// File: rtl/qq_pair_ram.sv
// qq_pair_ram
// DEPTH x bound_pair_t storage with one synchronous write port and one
// synchronous read port. The read register is the queue's output register:
// it only loads on rd_en and otherwise holds the last popped pair.
//   clk      rising-edge clock
//   rst      asynchronous active-low reset (clears the read register only)
//   wr_en    write wr_data into mem[wr_addr] at the edge
//   wr_addr  write address
//   wr_data  pair to store
//   rd_en    load mem[rd_addr] into the read register at the edge
//   rd_addr  read address
//   rd_data  registered read data
module qq_pair_ram
    import qq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  qq_ptr_t     wr_addr,
    input  bound_pair_t wr_data,
    input  logic        rd_en,
    input  qq_ptr_t     rd_addr,
    output bound_pair_t rd_data
);

    bound_pair_t mem [DEPTH];
    bound_pair_t rd_data_d;
    bound_pair_t rd_data_q;

    // Storage has no reset; its contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // A read of the address being written in the same cycle returns the old
    // contents. That only happens when the queue is completely full and the
    // head slot is also the next write slot, where the old data is the head.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/quick_queue_top.sv
// quick_queue_top
// FIFO of (left,right) bound pairs used as the QuickQ pending-subarray queue.
// The usable capacity is set at run time by array_size (0 selects DEPTH).
// Outputs show the last popped pair and change only on a pop or reset.
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   enq         push {data_lt_i, data_rt_i}
//   deq         pop the head into data_lt_o / data_rt_o
//   array_size  run-time capacity, 0 means DEPTH
//   data_lt_i   left bound to push
//   data_rt_i   right bound to push
//   data_lt_o   left bound of the last popped pair
//   data_rt_o   right bound of the last popped pair
module quick_queue_top
    import qq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              enq,
    input  logic              deq,
    input  logic [7:0]        array_size,
    input  logic [DATA_W-1:0] data_lt_i,
    input  logic [DATA_W-1:0] data_rt_i,
    output logic [DATA_W-1:0] data_lt_o,
    output logic [DATA_W-1:0] data_rt_o
);

    qq_count_t   count_d, count_q;
    qq_ptr_t     rd_ptr_d, rd_ptr_q;
    qq_ptr_t     wr_ptr_d, wr_ptr_q;
    qq_count_t   cap;
    logic        empty;
    logic        full;
    logic        pop_en;
    logic        push_en;
    bound_pair_t push_pair;
    bound_pair_t head_pair;

    function automatic qq_ptr_t ptr_inc(input qq_ptr_t p);
        return (p == qq_ptr_t'(DEPTH - 1)) ? '0 : p + qq_ptr_t'(1);
    endfunction

    always_comb begin
        cap   = (array_size == 8'd0) ? qq_count_t'(DEPTH) : {1'b0, array_size};
        empty = (count_q == '0);
        full  = (count_q >= cap);

        pop_en = deq && !empty;
        // A push alongside a pop is accepted at exactly full, since the
        // occupancy does not grow. If array_size was lowered below the
        // current count, pushes stay blocked until the queue drains below it.
        push_en = enq && (!full || (pop_en && (count_q == cap)));

        rd_ptr_d = pop_en  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = push_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;

        count_d = count_q;
        if (push_en && !pop_en) begin
            count_d = count_q + qq_count_t'(1);
        end else if (pop_en && !push_en) begin
            count_d = count_q - qq_count_t'(1);
        end

        push_pair.lt = data_lt_i;
        push_pair.rt = data_rt_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    qq_pair_ram u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_en),
        .wr_addr (wr_ptr_q),
        .wr_data (push_pair),
        .rd_en   (pop_en),
        .rd_addr (rd_ptr_q),
        .rd_data (head_pair)
    );

    assign data_lt_o = head_pair.lt;
    assign data_rt_o = head_pair.rt;

endmodule

// File: tb/tb_quick_queue_top.sv
module tb_quick_queue_top;

    logic        clk;
    logic        rst;
    logic        enq;
    logic        deq;
    logic [7:0]  array_size;
    logic [31:0] data_lt_i;
    logic [31:0] data_rt_i;
    logic [31:0] data_lt_o;
    logic [31:0] data_rt_o;

    int pass_cnt;
    int check_cnt;

    quick_queue_top dut (
        .clk        (clk),
        .rst        (rst),
        .enq        (enq),
        .deq        (deq),
        .array_size (array_size),
        .data_lt_i  (data_lt_i),
        .data_rt_i  (data_rt_i),
        .data_lt_o  (data_lt_o),
        .data_rt_o  (data_rt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and land 1 time unit after it.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        array_size = 8'd3;
        deq        = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_cnt++;
        if (data_lt_o !== 32'd0 || data_rt_o !== 32'd0)
            $display("FAIL reset_hold: got %0d/%0d want 0/0", data_lt_o, data_rt_o);
        else
            pass_cnt++;
        #2 rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_cnt++;
            if (data_lt_o !== 32'd0 || data_rt_o !== 32'd0)
                $display("FAIL empty_deq[%0d]: got %0d/%0d want 0/0", i, data_lt_o, data_rt_o);
            else
                pass_cnt++;
        end
        deq = 1'b0;
    endtask

    task automatic test_no_show_ahead();
        enq = 1'b1; data_lt_i = 32'd4; data_rt_i = 32'd9;
        cycle();
        enq = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check_cnt++;
            if (data_lt_o !== 32'd0 || data_rt_o !== 32'd0)
                $display("FAIL no_show_ahead[%0d]: got %0d/%0d want 0/0", i, data_lt_o, data_rt_o);
            else
                pass_cnt++;
        end
        deq = 1'b1;
        cycle();
        deq = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_cnt++;
            if (data_lt_o !== 32'd4 || data_rt_o !== 32'd9)
                $display("FAIL single_pop[%0d]: got %0d/%0d want 4/9", i, data_lt_o, data_rt_o);
            else
                pass_cnt++;
            cycle();
        end
    endtask

    task automatic test_capacity();
        logic [31:0] exp_lt [4];
        logic [31:0] exp_rt [4];
        exp_lt = '{32'd1, 32'd2, 32'd3, 32'd3};
        exp_rt = '{32'd10, 32'd20, 32'd30, 32'd30};
        array_size = 8'd3;
        enq = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            data_lt_i = 32'(i);
            data_rt_i = 32'(i * 10);
            cycle();
        end
        enq = 1'b0;
        deq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check_cnt++;
            if (data_lt_o !== exp_lt[i] || data_rt_o !== exp_rt[i])
                $display("FAIL cap3_pop[%0d]: got %0d/%0d want %0d/%0d",
                         i, data_lt_o, data_rt_o, exp_lt[i], exp_rt[i]);
            else
                pass_cnt++;
        end
        deq = 1'b0;
    endtask

    task automatic test_simultaneous();
        enq = 1'b1; data_lt_i = 32'd5; data_rt_i = 32'd50;
        cycle();
        data_lt_i = 32'd6; data_rt_i = 32'd60;
        deq = 1'b1;
        cycle();
        enq = 1'b0;
        check_cnt++;
        if (data_lt_o !== 32'd5 || data_rt_o !== 32'd50)
            $display("FAIL simul_pop: got %0d/%0d want 5/50", data_lt_o, data_rt_o);
        else
            pass_cnt++;
        cycle();
        check_cnt++;
        if (data_lt_o !== 32'd6 || data_rt_o !== 32'd60)
            $display("FAIL simul_next: got %0d/%0d want 6/60", data_lt_o, data_rt_o);
        else
            pass_cnt++;
        // Queue should now be empty, so another pop holds the outputs.
        cycle();
        check_cnt++;
        if (data_lt_o !== 32'd6 || data_rt_o !== 32'd60)
            $display("FAIL simul_drained: got %0d/%0d want 6/60", data_lt_o, data_rt_o);
        else
            pass_cnt++;
        deq = 1'b0;
    endtask

    // Fill all 256 entries, then push 256..299 while popping every other
    // cycle: even offsets find the queue full and are dropped, odd offsets
    // pop and push together. Finally drain everything across the wrap.
    task automatic test_wrap();
        logic [31:0] want;
        int          bad;
        array_size = 8'd0;
        enq = 1'b1;
        for (int i = 0; i < 256; i++) begin
            data_lt_i = 32'(i);
            data_rt_i = 32'(i * 7 + 1);
            cycle();
        end
        for (int j = 0; j < 44; j++) begin
            data_lt_i = 32'(256 + j);
            data_rt_i = 32'((256 + j) * 7 + 1);
            deq = (j % 2) == 1;
            cycle();
            if (j % 2 == 1) begin
                want = 32'((j - 1) / 2);
                check_cnt++;
                if (data_lt_o !== want || data_rt_o !== want * 7 + 1)
                    $display("FAIL full_pop[%0d]: got %0d/%0d want %0d/%0d",
                             j, data_lt_o, data_rt_o, want, want * 7 + 1);
                else
                    pass_cnt++;
            end
        end
        enq = 1'b0;
        deq = 1'b1;
        bad = 0;
        for (int k = 0; k < 256; k++) begin
            cycle();
            want = (k < 234) ? 32'(22 + k) : 32'(257 + 2 * (k - 234));
            check_cnt++;
            if (data_lt_o !== want || data_rt_o !== want * 7 + 1) begin
                if (bad < 8)
                    $display("FAIL drain[%0d]: got %0d/%0d want %0d/%0d",
                             k, data_lt_o, data_rt_o, want, want * 7 + 1);
                bad++;
            end else begin
                pass_cnt++;
            end
        end
        cycle();
        check_cnt++;
        if (data_lt_o !== 32'd299 || data_rt_o !== 32'd2094)
            $display("FAIL drain_empty: got %0d/%0d want 299/2094", data_lt_o, data_rt_o);
        else
            pass_cnt++;
        deq = 1'b0;
    endtask

    task automatic test_async_reset();
        enq = 1'b1; data_lt_i = 32'd11; data_rt_i = 32'd111;
        cycle();
        data_lt_i = 32'd12; data_rt_i = 32'd121;
        deq = 1'b1;
        cycle();
        enq = 1'b0;
        deq = 1'b0;
        check_cnt++;
        if (data_lt_o !== 32'd11 || data_rt_o !== 32'd111)
            $display("FAIL pre_reset: got %0d/%0d want 11/111", data_lt_o, data_rt_o);
        else
            pass_cnt++;
        #3 rst = 1'b0;
        #1;
        check_cnt++;
        if (data_lt_o !== 32'd0 || data_rt_o !== 32'd0)
            $display("FAIL async_clear: got %0d/%0d want 0/0", data_lt_o, data_rt_o);
        else
            pass_cnt++;
        #2 rst = 1'b1;
        deq = 1'b1;
        cycle();
        deq = 1'b0;
        check_cnt++;
        if (data_lt_o !== 32'd0 || data_rt_o !== 32'd0)
            $display("FAIL post_reset_empty: got %0d/%0d want 0/0", data_lt_o, data_rt_o);
        else
            pass_cnt++;
        enq = 1'b1; data_lt_i = 32'd77; data_rt_i = 32'd88;
        cycle();
        enq = 1'b0;
        deq = 1'b1;
        cycle();
        deq = 1'b0;
        check_cnt++;
        if (data_lt_o !== 32'd77 || data_rt_o !== 32'd88)
            $display("FAIL post_reset_push: got %0d/%0d want 77/88", data_lt_o, data_rt_o);
        else
            pass_cnt++;
    endtask

    initial begin
        pass_cnt   = 0;
        check_cnt  = 0;
        rst        = 1'b0;
        enq        = 1'b0;
        deq        = 1'b0;
        array_size = 8'd0;
        data_lt_i  = 32'd0;
        data_rt_i  = 32'd0;

        test_reset();
        test_no_show_ahead();
        test_capacity();
        test_simultaneous();
        test_wrap();
        test_async_reset();

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
